// File: rtl/mac_seq.sv
// mac_seq: issues 3-bit operand pairs to a sequential multiplier and sums each frame's products (MAC_SAT_EN: saturating sum)
module mac_seq #(
   parameter int ACC_W = 9
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [2:0]       a_bi,
   input  logic [2:0]       b_bi,
   input  logic             last_i,
   input  logic             valid_i,
   output logic             ready_o,
   output logic [2:0]       mul_a_bo,
   output logic [2:0]       mul_b_bo,
   output logic             mul_start_o,
   input  logic             mul_busy_i,
   input  logic [5:0]       mul_y_bi,
   output logic [ACC_W-1:0] y_bo,
   output logic             valid_o,
   output logic             ovf_o,
   output logic             busy_o
);
   typedef enum logic [2:0] {IDLE, ISSUE, WAIT_HI, WAIT_LO, DONE} state_t;
   state_t             r_state, w_next;
   logic [2:0]         r_a, r_b;
   logic               r_last, r_ovf, r_y_ovf;
   logic [ACC_W-1:0]   r_acc, r_y, w_acc_nx;
   logic [ACC_W:0]     w_sum;
   logic               w_ovf_nx, w_capture;
   assign w_sum     = {1'b0, r_acc} + {{(ACC_W-5){1'b0}}, mul_y_bi};
   assign w_ovf_nx  = r_ovf | w_sum[ACC_W];
   assign w_capture = (r_state == WAIT_LO) && !mul_busy_i;
`ifdef MAC_SAT_EN
   assign w_acc_nx  = w_ovf_nx ? '1 : w_sum[ACC_W-1:0];
`else
   assign w_acc_nx  = w_sum[ACC_W-1:0];
`endif
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = valid_i ? ISSUE : IDLE;
         ISSUE:   w_next = WAIT_HI;
         WAIT_HI: w_next = mul_busy_i ? WAIT_LO : WAIT_HI;
         WAIT_LO: w_next = mul_busy_i ? WAIT_LO : (r_last ? DONE : IDLE);
         default: w_next = IDLE;
      endcase
   end
   // the frame result is registered as DONE is entered so it is visible alongside valid_o
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_last  <= 1'b0;
         r_acc   <= '0;
         r_ovf   <= 1'b0;
         r_y     <= '0;
         r_y_ovf <= 1'b0;
      end else begin
         r_state <= w_next;
         if (r_state == IDLE && valid_i) begin
            r_a    <= a_bi;
            r_b    <= b_bi;
            r_last <= last_i;
         end
         if (w_capture && r_last) begin
            r_y     <= w_acc_nx;
            r_y_ovf <= w_ovf_nx;
            r_acc   <= '0;
            r_ovf   <= 1'b0;
         end else if (w_capture) begin
            r_acc <= w_acc_nx;
            r_ovf <= w_ovf_nx;
         end
      end
   end
   assign ready_o     = r_state == IDLE;
   assign busy_o      = r_state != IDLE;
   assign mul_start_o = r_state == ISSUE;
   assign valid_o     = r_state == DONE;
   assign mul_a_bo    = r_a;
   assign mul_b_bo    = r_b;
   assign y_bo        = r_y;
   assign ovf_o       = r_y_ovf;
endmodule
